// File: rtl/ysyx_24080014_pkg.sv
// Shared types for the data SRAM: FSM state encoding, latency counter width, byte-lane count.
package ysyx_24080014_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;

endpackage

// File: rtl/ysyx_24080014_sram_array.sv
// Word storage: one synchronous byte-enable write port, one combinational read port.
// Contents are never reset.
module ysyx_24080014_sram_array
  import ysyx_24080014_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    widx,
  input  logic [31:0]      wdata,
  input  logic [LANES-1:0] wbe,
  input  logic [AW-1:0]    ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_24080014_data_sram.sv
// Fixed-latency data SRAM: one outstanding access, mem_ready pulses LATENCY cycles after accept;
// requests arriving while busy are dropped. Define YSYX_24080014_SRAM_ERR_EN to fault out-of-range addresses.
module ysyx_24080014_data_sram
  import ysyx_24080014_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] raddr,
  input  logic [31:0] waddr,
  input  logic [31:0] din,
  input  logic [7:0]  wmask,
  output logic        mem_ready,
  output logic [31:0] dout,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ren_q, wen_q;
  logic [31:0]      raddr_q, waddr_q, din_q;
  logic [LANES-1:0] wmask_q;

  logic        idle, cur_ren, cur_wen, rd_bad, wr_bad, acc_bad, enter_resp, we;
  logic [31:0] cur_raddr, cur_waddr, rd_word;
  logic        unused_mask;

  // With LATENCY=1 the response is built on the accept edge itself, so read
  // the live request instead of the not-yet-latched copy.
  assign idle      = (state == S_IDLE);
  assign cur_ren   = idle ? ren   : ren_q;
  assign cur_wen   = idle ? wen   : wen_q;
  assign cur_raddr = idle ? raddr : raddr_q;
  assign cur_waddr = idle ? waddr : waddr_q;

`ifdef YSYX_24080014_SRAM_ERR_EN
  assign rd_bad = |cur_raddr[31:AW+2];
  assign wr_bad = |cur_waddr[31:AW+2];
`else
  logic unused_hi;
  assign rd_bad    = 1'b0;
  assign wr_bad    = 1'b0;
  assign unused_hi = ^{cur_raddr[31:AW+2], cur_waddr[31:AW+2]};
`endif

  assign unused_mask = ^wmask[7:4];
  assign acc_bad     = (cur_ren & rd_bad) | (cur_wen & wr_bad);
  assign enter_resp  = (idle && (ren || wen) && (LATENCY == 1)) ||
                       (state == S_WAIT && cnt == CNT_W'(1));

  // Commit happens on the edge leaving RESP, after dout was captured: read-before-write.
  assign we = (state == S_RESP) && wen_q && !err && !rst;

  ysyx_24080014_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we),
    .widx  (waddr_q[AW+1:2]),
    .wdata (din_q),
    .wbe   (wmask_q),
    .ridx  (cur_raddr[AW+1:2]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_ready <= 1'b0;
      dout      <= '0;
      err       <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      din_q     <= '0;
      wmask_q   <= '0;
    end else begin
      mem_ready <= enter_resp;
      err       <= enter_resp & acc_bad;
      if (enter_resp) begin
        if (acc_bad)      dout <= '0;
        else if (cur_ren) dout <= rd_word >> {cur_raddr[1:0], 3'b000};
      end
      case (state)
        S_IDLE: begin
          if (ren || wen) begin
            ren_q   <= ren;
            wen_q   <= wen;
            raddr_q <= raddr;
            waddr_q <= waddr;
            din_q   <= din;
            wmask_q <= wmask[LANES-1:0];
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_data_sram.sv
// Bench for the data SRAM: default instance (DEPTH=1024, LATENCY=2) plus a LATENCY=1 instance.
module tb_ysyx_24080014_data_sram;

`ifdef YSYX_24080014_SRAM_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ren [2];
  logic        wen [2];
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] din [2];
  logic [7:0]  wmask [2];
  logic        mem_ready [2];
  logic [31:0] dout [2];
  logic        err [2];

  always #5 clk = ~clk;

  ysyx_24080014_data_sram u_dut (
    .clk(clk), .rst(rst), .ren(ren[0]), .wen(wen[0]), .raddr(raddr[0]), .waddr(waddr[0]),
    .din(din[0]), .wmask(wmask[0]), .mem_ready(mem_ready[0]), .dout(dout[0]), .err(err[0])
  );

  ysyx_24080014_data_sram #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .ren(ren[1]), .wen(wen[1]), .raddr(raddr[1]), .waddr(waddr[1]),
    .din(din[1]), .wmask(wmask[1]), .mem_ready(mem_ready[1]), .dout(dout[1]), .err(err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference memory for the default instance, keyed by word index.
  logic [31:0] mdl [int];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return mdl[int'(a[11:2])] >> (8 * a[1:0]);
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    logic [31:0] w;
    w = mdl.exists(int'(a[11:2])) ? mdl[int'(a[11:2])] : 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[int'(a[11:2])] = w;
  endtask

  // One request; returns cycles from accept edge to mem_ready (0 = timeout), then checks the pulse ends.
  task automatic xact(input int d, input logic r, input logic w, input logic [31:0] ra,
                      input logic [31:0] wa, input logic [31:0] dd, input logic [7:0] wm,
                      output logic [31:0] od, output logic oe, output int lat);
    @(negedge clk);
    ren[d] = r; wen[d] = w; raddr[d] = ra; waddr[d] = wa; din[d] = dd; wmask[d] = wm;
    @(posedge clk);
    lat = 0; od = '0; oe = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin ren[d] = 1'b0; wen[d] = 1'b0; end
      if (mem_ready[d]) begin
        lat = i; od = dout[d]; oe = err[d];
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      chk("pulse_width", {31'b0, mem_ready[d]}, 32'h0);
    end
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] ra, wa, dd;
    logic [7:0]  wm;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] od, last, exp_d, ra, wa, dd;
    logic        oe, r, w;
    logic [7:0]  wm;
    int          lat;

    tbl[0]  = '{1'b0, 1'b1, 32'h0,   32'h0,   32'h12345678, 8'h0F, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0,   32'h100, 32'hDEADBEEF, 8'h0F, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h100, 32'h0,   32'h0,        8'h00, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,   32'h100, 32'h000000AA, 8'h01, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h100, 32'h0,   32'h0,        8'h00, 32'hDEADBEAA, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h101, 32'h0,   32'h0,        8'h00, 32'h00DEADBE, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,   32'h200, 32'h11111111, 8'h0F, 32'h00DEADBE, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 32'h200, 32'h200, 32'h22222222, 8'h0F, 32'h11111111, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h200, 32'h0,   32'h0,        8'h00, 32'h22222222, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h0,   32'h100, 32'hFFFFFFFF, 8'hF0, 32'h22222222, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'h103, 32'h0,   32'h0,        8'h00, 32'h000000DE, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h00010000, 32'h0, 32'h0,     8'h00,
                ERR_ON ? 32'h0 : 32'h12345678, ERR_ON};

    for (int d = 0; d < 2; d++) begin
      ren[d] = 1'b0; wen[d] = 1'b0; raddr[d] = '0; waddr[d] = '0; din[d] = '0; wmask[d] = '0;
    end
    rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", {31'b0, mem_ready[d]}, 32'h0);
      chk("reset_dout", dout[d], 32'h0);
      chk("reset_err", {31'b0, err[d]}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table on the default instance.
    foreach (tbl[i]) begin
      xact(0, tbl[i].r, tbl[i].w, tbl[i].ra, tbl[i].wa, tbl[i].dd, tbl[i].wm, od, oe, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd2);
      chk($sformatf("tbl%0d_dout", i), od, tbl[i].ed);
      chk($sformatf("tbl%0d_err", i), {31'b0, oe}, {31'b0, tbl[i].ee});
    end
    last = tbl[11].ed;

    // Randomised traffic over words 0x100..0x10F against the reference model.
    for (int i = 0; i < 16; i++) begin
      dd = $urandom;
      xact(0, 1'b0, 1'b1, 32'h0, 32'h400 + 32'(4 * i), dd, 8'h0F, od, oe, lat);
      ref_wr(32'h400 + 32'(4 * i), dd, 8'h0F);
      chk("init_dout", od, last);
    end
    for (int i = 0; i < 80; i++) begin
      r  = 1'($urandom_range(0, 1));
      w  = r ? 1'($urandom_range(0, 1)) : 1'b1;
      ra = 32'h400 + 32'($urandom_range(0, 63));
      wa = 32'h400 + 32'($urandom_range(0, 63));
      dd = $urandom;
      wm = 8'($urandom);
      exp_d = r ? ref_rd(ra) : last;
      xact(0, r, w, ra, wa, dd, wm, od, oe, lat);
      if (w) ref_wr(wa, dd, wm);
      last = exp_d;
      chk($sformatf("rand%0d_latency", i), lat, 32'd2);
      chk($sformatf("rand%0d_dout", i), od, exp_d);
      chk($sformatf("rand%0d_err", i), {31'b0, oe}, 32'h0);
    end

    // Reset during WAIT of a write: outputs clear at once, write is dropped.
    xact(0, 1'b0, 1'b1, 32'h0, 32'h300, 32'hCAFEF00D, 8'h0F, od, oe, lat);
    xact(0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 8'h00, od, oe, lat);
    chk("pre_rst_dout", od, 32'hCAFEF00D);
    @(negedge clk);
    wen[0] = 1'b1; waddr[0] = 32'h300; din[0] = 32'h0BADBEEF; wmask[0] = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    wen[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, mem_ready[0]}, 32'h0);
    chk("rst_dout", dout[0], 32'h0);
    chk("rst_err", {31'b0, err[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    xact(0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 8'h00, od, oe, lat);
    chk("post_rst_latency", lat, 32'd2);
    chk("post_rst_dout", od, 32'hCAFEF00D);

    // LATENCY=1 instance: back-to-back reads, then a request held through RESP.
    xact(1, 1'b0, 1'b1, 32'h0, 32'h10, 32'hA1B2C3D4, 8'h0F, od, oe, lat);
    chk("l1_wr_latency", lat, 32'd1);
    xact(1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 8'h00, od, oe, lat);
    chk("l1_rd0_latency", lat, 32'd1);
    chk("l1_rd0_dout", od, 32'hA1B2C3D4);
    xact(1, 1'b1, 1'b0, 32'h12, 32'h0, 32'h0, 8'h00, od, oe, lat);
    chk("l1_rd1_latency", lat, 32'd1);
    chk("l1_rd1_dout", od, 32'h0000A1B2);
    @(negedge clk);
    ren[1] = 1'b1; raddr[1] = 32'h11;
    @(posedge clk);
    @(negedge clk);
    chk("l1_hold_ready", {31'b0, mem_ready[1]}, 32'h1);
    chk("l1_hold_dout", dout[1], 32'h00A1B2C3);
    @(posedge clk);
    @(negedge clk);
    ren[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("l1_no_extra", {31'b0, mem_ready[1]}, 32'h0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
